// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: PC source, instruction memory port and decode-side valid/ready.
interface fetch_queue_if;
  logic [31:0] pc_address;
  logic        pc_valid;
  logic        alignment_error;
  logic        flush;
  logic        stall_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_adel;
  logic        inst_ready;

  modport master (
    output pc_address, pc_valid, alignment_error, flush,
           imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  stall_o, imem_req, imem_addr,
           inst_valid, inst_data, inst_pc, inst_adel
  );

  modport slave (
    input  pc_address, pc_valid, alignment_error, flush,
           imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output stall_o, imem_req, imem_addr,
           inst_valid, inst_data, inst_pc, inst_adel
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited memory requests, in-order response pairing,
// flush-time response discard and a DEPTH-entry instruction buffer toward decode.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] outstanding, discard, count;
  logic [PW-1:0] a_wr, a_rd, b_wr, b_rd;

  logic [31:0]      afifo [DEPTH];
  logic [31:0]      bdata [DEPTH];
  logic [31:0]      bpc   [DEPTH];
  logic [DEPTH-1:0] badel;

  logic [CW:0] credit_sum;
  logic        in_flight, rsp, drop, deliver;
  logic        accept, mis_enq, push, pop;

  assign credit_sum = {1'b0, outstanding} + {1'b0, count};
  assign in_flight  = (outstanding != '0) || (discard != '0);
  // Responses with nothing in flight are a protocol error and are ignored.
  assign rsp        = bus.imem_rvalid & in_flight;
  assign drop       = rsp & (discard != '0);
  assign deliver    = rsp & (discard == '0);

  assign bus.imem_req  = bus.pc_valid & ~bus.flush & ~bus.alignment_error & ~rst &
                         (credit_sum < (CW+1)'(DEPTH));
  assign bus.imem_addr = bus.pc_address;
  assign accept        = bus.imem_req & bus.imem_gnt;

  // A misaligned fetch waits for older responses so the buffer stays in program order.
  assign mis_enq = bus.pc_valid & bus.alignment_error & ~bus.flush & ~rst &
                   (outstanding == '0) & (count < CW'(DEPTH));

  assign bus.stall_o = rst | (~bus.flush & ~(accept | mis_enq));

  assign push = deliver | mis_enq;
  assign pop  = bus.inst_valid & bus.inst_ready;

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = bdata[b_rd];
  assign bus.inst_pc    = bpc[b_rd];
  assign bus.inst_adel  = badel[b_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      a_wr        <= '0;
      a_rd        <= '0;
      b_wr        <= '0;
      b_rd        <= '0;
    end else begin
      if (accept) a_wr <= a_wr + 1'b1;
      if (rsp)    a_rd <= a_rd + 1'b1;
      if (bus.flush) begin
        // Everything still in flight becomes garbage; a response taken this cycle is gone.
        outstanding <= '0;
        discard     <= discard + outstanding - CW'(rsp);
        count       <= '0;
        b_wr        <= '0;
        b_rd        <= '0;
      end else begin
        outstanding <= outstanding + CW'(accept) - CW'(deliver);
        discard     <= discard - CW'(drop);
        count       <= count + CW'(push) - CW'(pop);
        if (push) b_wr <= b_wr + 1'b1;
        if (pop)  b_rd <= b_rd + 1'b1;
      end
    end
  end

  // Storage carries no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (accept) afifo[a_wr] <= bus.pc_address;
    if (push && !bus.flush) begin
      bdata[b_wr] <= deliver ? bus.imem_rdata : 32'h0;
      bpc[b_wr]   <= deliver ? afifo[a_rd] : bus.pc_address;
      badel[b_wr] <= ~deliver;
    end
  end
endmodule
